// File: rtl/st_fanout_pkg.sv
// st_fanout_pkg
// Types and constants shared by the stream fan-out buffer and its FIFOs.
//   beat_t        : one Avalon-ST beat (data, sop, eop) at the default width
//   frame_state_t : input-side packet framing state
//   MAX_OUT       : upper bound on the number of broadcast outputs
package st_fanout_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int MAX_OUT        = 8;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] data;
    logic                      sop;
    logic                      eop;
  } beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/st_fifo_fwft.sv
// st_fifo_fwft
// Small first-word-fall-through FIFO holding stream beats. The head entry is
// read straight out of the storage array, so a beat written at one edge is
// visible on head right after that edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push       : write push_beat (ignored while full)
//   push_beat  : beat to store
//   full       : DEPTH entries held
//   pop        : discard the head entry (ignored while empty)
//   empty      : no entries held
//   head       : oldest entry, don't-care while empty
module st_fifo_fwft #(
  parameter int  DEPTH  = 4,
  parameter type beat_t = st_fanout_pkg::beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  beat_t push_beat,
  output logic  full,
  input  logic  pop,
  output logic  empty,
  output beat_t head
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_beat;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); a simultaneous push and
  // pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/st_fanout_buf.sv
// st_fanout_buf
// Broadcasts one Avalon-ST byte stream to NUM_OUT sinks, each behind its own
// FWFT FIFO, so a briefly stalled sink does not stall the others beat for
// beat. Also checks input packet framing and counts accepted packets.
// Ports:
//   clk, rst_n      : stream clock, asynchronous active-low reset
//   snk_*           : input stream (data, valid, sop, eop, ready)
//   src_*           : NUM_OUT output streams, output i in slice/bit i
//   frame_err       : sticky framing error, cleared by err_clr (set wins)
//   err_clr         : synchronous clear of frame_err
//   pkt_cnt         : packets accepted at the input, counted on eop, wraps
module st_fanout_buf
  import st_fanout_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         snk_data,
  input  logic                      snk_valid,
  input  logic                      snk_sop,
  input  logic                      snk_eop,
  output logic                      snk_ready,
  output logic [NUM_OUT*DATA_W-1:0] src_data,
  output logic [NUM_OUT-1:0]        src_valid,
  output logic [NUM_OUT-1:0]        src_sop,
  output logic [NUM_OUT-1:0]        src_eop,
  input  logic [NUM_OUT-1:0]        src_ready,
  output logic                      frame_err,
  input  logic                      err_clr,
  output logic [31:0]               pkt_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } lane_beat_t;

  lane_beat_t         in_beat;
  lane_beat_t         head [NUM_OUT];
  logic [NUM_OUT-1:0] fifo_full;
  logic [NUM_OUT-1:0] fifo_empty;
  logic [NUM_OUT-1:0] fifo_pop;
  logic               ready_en;
  logic               acc;
  frame_state_t       state;
  frame_state_t       state_nxt;
  logic               pkt_done;
  logic               err_set;

  assign in_beat = {snk_data, snk_sop, snk_eop};

  // Ready looks only at registered FIFO fullness, never at src_ready, so a
  // full FIFO blocks the input even in a cycle where it is being popped.
  assign snk_ready = ready_en & ~(|fifo_full);
  assign acc       = snk_valid & snk_ready;

  // Holds snk_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Every accepted beat goes into every FIFO; each output drains on its own.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    st_fifo_fwft #(
      .DEPTH  (DEPTH),
      .beat_t (lane_beat_t)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (acc),
      .push_beat (in_beat),
      .full      (fifo_full[i]),
      .pop       (fifo_pop[i]),
      .empty     (fifo_empty[i]),
      .head      (head[i])
    );

    assign src_valid[i]                  = ~fifo_empty[i];
    assign fifo_pop[i]                   = src_valid[i] & src_ready[i];
    assign src_data[i*DATA_W +: DATA_W]  = head[i].data;
    assign src_sop[i]                    = head[i].sop;
    assign src_eop[i]                    = head[i].eop;
  end

  // Framing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Framing next-state: advances only on accepted beats. A stray sop inside
  // a packet is flagged but restarts the packet; errored beats are still
  // forwarded because the FIFOs are written on every accept regardless.
  always_comb begin
    state_nxt = state;
    pkt_done  = 1'b0;
    err_set   = 1'b0;
    if (acc) begin
      case (state)
        IDLE: begin
          if (!snk_sop) begin
            err_set = 1'b1;
          end else if (snk_eop) begin
            pkt_done = 1'b1;
          end else begin
            state_nxt = IN_PKT;
          end
        end
        IN_PKT: begin
          err_set = snk_sop;
          if (snk_eop) begin
            pkt_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  // Packet counter and sticky error flag; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      if (pkt_done) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (err_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_st_fanout_buf.sv
// tb_st_fanout_buf
// Directed self-checking bench for st_fanout_buf (DATA_W=8, NUM_OUT=2,
// DEPTH=4). Accepted input beats are pushed to one expected queue per output
// and popped/compared whenever that output hands over a beat.
module tb_st_fanout_buf;

  localparam int DATA_W  = 8;
  localparam int NUM_OUT = 2;
  localparam int DEPTH   = 4;

  logic                      clk;
  logic                      rst_n;
  logic [DATA_W-1:0]         snk_data;
  logic                      snk_valid;
  logic                      snk_sop;
  logic                      snk_eop;
  logic                      snk_ready;
  logic [NUM_OUT*DATA_W-1:0] src_data;
  logic [NUM_OUT-1:0]        src_valid;
  logic [NUM_OUT-1:0]        src_sop;
  logic [NUM_OUT-1:0]        src_eop;
  logic [NUM_OUT-1:0]        src_ready;
  logic                      frame_err;
  logic                      err_clr;
  logic [31:0]               pkt_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          acc_cnt  = 0;
  int          pop_cnt0 = 0;
  int          pop_cnt1 = 0;
  int          cyc      = 0;
  logic [31:0] exp_pkt;
  logic [9:0]  q0 [$];
  logic [9:0]  q1 [$];

  st_fanout_buf #(
    .DATA_W  (DATA_W),
    .NUM_OUT (NUM_OUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_sop   (snk_sop),
    .snk_eop   (snk_eop),
    .snk_ready (snk_ready),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .src_ready (src_ready),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .pkt_cnt   (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Single comparison point: counts every check and reports any miss.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard, sampled on the falling edge: pops describe handovers and
  // accepts describe writes that happen at the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (src_valid[0] && src_ready[0]) begin
        pop_cnt0++;
        check_output("sb_out0_expected", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0)
          check_output("sb_out0_beat", 32'({src_data[7:0], src_sop[0], src_eop[0]}), 32'(q0.pop_front()));
      end
      if (src_valid[1] && src_ready[1]) begin
        pop_cnt1++;
        check_output("sb_out1_expected", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0)
          check_output("sb_out1_beat", 32'({src_data[15:8], src_sop[1], src_eop[1]}), 32'(q1.pop_front()));
      end
      if (snk_valid && snk_ready) begin
        acc_cnt++;
        q0.push_back({snk_data, snk_sop, snk_eop});
        q1.push_back({snk_data, snk_sop, snk_eop});
      end
    end
  end

  // Drives one beat and returns just after the edge that accepted it, with
  // valid still high so consecutive calls stream one beat per cycle.
  task automatic apply_stimulus(input logic [7:0] d, input logic sop, input logic eop);
    bit done;
    done      = 1'b0;
    snk_data  = d;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (snk_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    if (!done) check_output("snk_accept_timeout", 32'(snk_ready), 32'd1);
  endtask

  task automatic idle();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_data  = '0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && src_valid !== '0; k++) begin
      @(posedge clk);
      #1;
    end
    check_output("drain_src_valid", 32'(src_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_acc;
    int base_p0;
    int base_p1;
    int c0;
    int c1;

    rst_n     = 1'b0;
    src_ready = '0;
    err_clr   = 1'b0;
    exp_pkt   = 32'd0;
    idle();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_snk_ready", 32'(snk_ready), 32'd0);
    check_output("rst_src_valid", 32'(src_valid), 32'd0);
    check_output("rst_pkt_cnt", pkt_cnt, 32'd0);
    check_output("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("release_snk_ready_pre_edge", 32'(snk_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("release_snk_ready", 32'(snk_ready), 32'd1);

    // Single beat to both outputs.
    $display("[TB] single beat");
    src_ready = 2'b11;
    apply_stimulus(8'h41, 1'b1, 1'b1);
    idle();
    exp_pkt = 32'd1;
    check_output("t1_src_valid", 32'(src_valid), 32'h3);
    check_output("t1_src_data", 32'(src_data), 32'h4141);
    check_output("t1_src_sop", 32'(src_sop), 32'h3);
    check_output("t1_src_eop", 32'(src_eop), 32'h3);
    check_output("t1_pkt_cnt", pkt_cnt, exp_pkt);
    check_output("t1_frame_err", 32'(frame_err), 32'd0);
    wait_drain();

    // Output 1 stalled: only DEPTH beats fit before the input blocks.
    $display("[TB] stalled consumer");
    src_ready = 2'b01;
    base_acc  = acc_cnt;
    base_p0   = pop_cnt0;
    base_p1   = pop_cnt1;
    for (int i = 0; i < 4; i++) apply_stimulus(8'(i), i == 0, 1'b0);
    snk_data  = 8'h04;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_output("t2_snk_ready_blocked", 32'(snk_ready), 32'd0);
    check_output("t2_accepted", 32'(acc_cnt - base_acc), 32'(DEPTH));
    check_output("t2_src_valid", 32'(src_valid), 32'h2);
    check_output("t2_out0_pops", 32'(pop_cnt0 - base_p0), 32'(DEPTH));
    src_ready = 2'b11;
    for (int i = 4; i < 8; i++) apply_stimulus(8'(i), 1'b0, i == 7);
    idle();
    exp_pkt = 32'd2;
    wait_drain();
    check_output("t2_out0_total", 32'(pop_cnt0 - base_p0), 32'd8);
    check_output("t2_out1_total", 32'(pop_cnt1 - base_p1), 32'd8);
    check_output("t2_pkt_cnt", pkt_cnt, exp_pkt);

    // Both FIFOs full while being popped: the offered beat is refused.
    $display("[TB] full with pop");
    src_ready = 2'b00;
    apply_stimulus(8'h10, 1'b1, 1'b0);
    apply_stimulus(8'h11, 1'b0, 1'b0);
    apply_stimulus(8'h12, 1'b0, 1'b0);
    apply_stimulus(8'h13, 1'b0, 1'b1);
    exp_pkt   = 32'd3;
    src_ready = 2'b11;
    snk_data  = 8'h20;
    snk_sop   = 1'b1;
    snk_eop   = 1'b1;
    base_acc  = acc_cnt;
    @(negedge clk);
    check_output("t3_snk_ready_full", 32'(snk_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("t3_snk_ready_next", 32'(snk_ready), 32'd1);
    check_output("t3_not_accepted", 32'(acc_cnt - base_acc), 32'd0);
    idle();
    wait_drain();
    check_output("t3_pkt_cnt", pkt_cnt, exp_pkt);

    // Framing errors.
    $display("[TB] framing errors");
    check_output("t4_err_start", 32'(frame_err), 32'd0);
    apply_stimulus(8'h30, 1'b0, 1'b0);
    idle();
    check_output("t4_err_no_sop", 32'(frame_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check_output("t4_err_cleared", 32'(frame_err), 32'd0);
    apply_stimulus(8'h31, 1'b1, 1'b0);
    apply_stimulus(8'h32, 1'b1, 1'b0);
    apply_stimulus(8'h33, 1'b0, 1'b1);
    idle();
    exp_pkt = 32'd4;
    check_output("t4_err_double_sop", 32'(frame_err), 32'd1);
    check_output("t4_pkt_cnt", pkt_cnt, exp_pkt);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    check_output("t4_err_cleared2", 32'(frame_err), 32'd0);
    apply_stimulus(8'h34, 1'b0, 1'b0);
    idle();
    err_clr = 1'b0;
    check_output("t4_set_beats_clear", 32'(frame_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check_output("t4_err_cleared3", 32'(frame_err), 32'd0);
    wait_drain();

    // 64-beat packet at full rate; pointers wrap many times.
    $display("[TB] throughput");
    src_ready = 2'b11;
    base_p0   = pop_cnt0;
    base_p1   = pop_cnt1;
    c0        = cyc;
    for (int i = 0; i < 64; i++) apply_stimulus(8'(i) + 8'h80, i == 0, i == 63);
    c1 = cyc;
    idle();
    exp_pkt = 32'd5;
    check_output("t5_input_cycles", 32'(c1 - c0), 32'd64);
    @(posedge clk);
    #1;
    check_output("t5_out0_pops", 32'(pop_cnt0 - base_p0), 32'd64);
    check_output("t5_out1_pops", 32'(pop_cnt1 - base_p1), 32'd64);
    check_output("t5_src_valid", 32'(src_valid), 32'd0);
    check_output("t5_pkt_cnt", pkt_cnt, exp_pkt);
    check_output("t5_frame_err", 32'(frame_err), 32'd0);

    // Reset in the middle of a buffered packet.
    $display("[TB] reset mid-packet");
    src_ready = 2'b00;
    apply_stimulus(8'h50, 1'b1, 1'b0);
    apply_stimulus(8'h51, 1'b0, 1'b0);
    apply_stimulus(8'h52, 1'b0, 1'b0);
    idle();
    check_output("t6_buffered_valid", 32'(src_valid), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_src_valid", 32'(src_valid), 32'd0);
    check_output("t6_rst_snk_ready", 32'(snk_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_pkt = 32'd0;
    check_output("t6_rst_pkt_cnt", pkt_cnt, exp_pkt);
    rst_n     = 1'b1;
    src_ready = 2'b11;
    apply_stimulus(8'h60, 1'b1, 1'b0);
    idle();
    check_output("t6_fresh_no_err", 32'(frame_err), 32'd0);
    check_output("t6_fresh_valid", 32'(src_valid), 32'h3);
    check_output("t6_fresh_data", 32'(src_data), 32'h6060);
    apply_stimulus(8'h61, 1'b0, 1'b1);
    idle();
    exp_pkt = 32'd1;
    check_output("t6_pkt_cnt", pkt_cnt, exp_pkt);
    check_output("t6_frame_err", 32'(frame_err), 32'd0);
    wait_drain();
    check_output("sb_q0_empty", 32'(q0.size()), 32'd0);
    check_output("sb_q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
